fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the fetch stage against a variable-latency instruction memory using a req/ack handshake.
//  Drives the PC enable and next-PC select, and the F->D stall/flush controls. A one-entry skid buffer
//  holds an instruction that returns while decode is stalled. A branch redirect that arrives while a
//  fetch is outstanding is queued until that fetch completes. Sits between hazard unit, PC and IMEM.
// PARAMETERS
//  ACK_TIMEOUT  255  max cycles a request may wait for imem_ack before fetch_err sets (1..65535)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous reset, active-low
//  PCSrcE       in   1   branch/jump taken in execute (redirect request)
//  PCTargetE    in   32  redirect target
//  PCPlus4F     in   32  sequential next PC from PC adder
//  StallReqD    in   1   hazard unit requests decode stall (load-use)
//  imem_ack     in   1   IMEM read data valid this cycle
//  imem_rdata   in   32  IMEM read data
//  imem_req     out  1   read request for address PCF; held until ack
//  PCEnF        out  1   PC register load enable
//  PCNextF      out  32  value loaded into PC when PCEnF=1
//  InstrF       out  32  instruction to F->D register
//  InstrValidF  out  1   InstrF valid (D register loads it)
//  StallD       out  1   hold F->D register
//  FlushD       out  1   clear F->D register (bubble)
//  FlushE       out  1   clear D->E register
//  fetch_err    out  1   sticky timeout flag
//  perf_wait    out  32  cycles spent waiting on imem_ack (see CONFIGURATION)
//  perf_redir   out  32  redirects taken (see CONFIGURATION)
// BEHAVIOUR
//  States: IDLE, REQ, HOLD, KILL. Reset -> IDLE, buf_valid=0, redir_reg=0, timer=0, fetch_err=0.
//  Outputs are combinational from state and inputs. Priority: rst > PCSrcE > ack/stall.
//  IDLE: imem_req=0, PCEnF=0, FlushD=1. Lasts exactly 1 cycle after reset release, then -> REQ.
//  REQ: imem_req=1.
//   - !ack: PCEnF=0. If StallReqD, StallD=1; else FlushD=1. timer++.
//   - ack & !StallReqD: InstrF=imem_rdata, InstrValidF=1, PCEnF=1, PCNextF=PCPlus4F. Stay in REQ.
//   - ack & StallReqD: capture rdata into buffer, PCEnF=1, PCNextF=PCPlus4F, StallD=1, -> HOLD.
//  HOLD: imem_req=0, InstrF=buffer. While StallReqD, StallD=1.
//   When StallReqD falls: InstrValidF=1, buffer cleared, -> REQ.
//  PCSrcE=1 (any state): FlushD=1, FlushE=1, StallD=0, buffer discarded, perf_redir++.
//   - In IDLE, HOLD, or REQ with ack: PCEnF=1, PCNextF=PCTargetE, -> REQ. Acked data dropped.
//   - In REQ without ack: redir_reg<=PCTargetE, PCEnF=0, -> KILL.
//  KILL: imem_req=1, FlushD=1, PCEnF=0. On ack: data discarded, PCEnF=1, PCNextF=redir_reg, -> REQ.
//   A further PCSrcE in KILL overwrites redir_reg; if it coincides with ack, PCTargetE wins.
//  InstrValidF=0 whenever FlushD=1; StallD and FlushD never both 1.
//  Timer: counts consecutive un-acked cycles in REQ/KILL; clears on ack or state exit.
//   When timer reaches ACK_TIMEOUT, fetch_err<=1. fetch_err clears only on reset.
//  Reset mid-request: imem_req drops asynchronously, all state is cleared, IMEM must tolerate an
//   abandoned request. A late ack arriving in IDLE is ignored.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: perf_wait increments on each REQ/KILL cycle with imem_ack=0.
//   perf_redir increments on each PCSrcE=1 cycle. Both are 32-bit, wrap, and reset to 0.
//  FETCH_PERF_CNT_EN undefined: counters are not built; perf_wait=perf_redir=0 constant.
// TESTING
//  Zero-wait IMEM (ack every cycle), no stalls -> PCEnF=1 each cycle, PCNextF=PCPlus4F.
//   InstrValidF=1 from the 2nd cycle after reset.
//  Ack delayed 3 cycles -> 3 cycles of PCEnF=0, FlushD=1, then one valid instruction.
//   perf_wait=3 when the macro is defined.
//  StallReqD=1 for 4 cycles, ack on the 1st -> HOLD. imem_req=0 for 3 cycles, StallD=1.
//   On release, buffered InstrF (e.g. 32'h00500093) issues with InstrValidF=1.
//  PCSrcE with PCTargetE=32'h40 while ack is pending 2 more cycles -> KILL. FlushD=FlushE=1.
//   Acked data is dropped, then PCNextF=32'h40 with PCEnF=1.
//  ACK_TIMEOUT=4, ack never returns -> fetch_err=1 after the 4th un-acked cycle; stays 1 until rst.
//  Assert rst mid-KILL -> imem_req=0 immediately. After release: IDLE 1 cycle, then REQ.
//   fetch_err=0, redir_reg unused.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives IMEM req/ack handshake, PC load control and F->D/D->E stall/flush.
// One-entry skid buffer holds an instruction that returns while decode is stalled; a redirect
// that arrives during an outstanding fetch is parked until that fetch is acked.
// Optional feature: define FETCH_PERF_CNT_EN to build the perf_wait/perf_redir counters.
module fetch_sequencer #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic [31:0] PCPlus4F,
   input  logic        StallReqD,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic        PCEnF,
   output logic [31:0] PCNextF,
   output logic [31:0] InstrF,
   output logic        InstrValidF,
   output logic        StallD,
   output logic        FlushD,
   output logic        FlushE,
   output logic        fetch_err,
   output logic [31:0] perf_wait,
   output logic [31:0] perf_redir
);

   typedef enum logic [1:0] {StIdle, StReq, StHold, StKill} state_e;

   localparam logic [15:0] TimeoutVal = ACK_TIMEOUT[15:0];

   state_e      state_q, state_d;
   logic [31:0] buf_q;
   logic        buf_valid_q;
   logic [31:0] redir_q;
   logic [15:0] timer_q;
   logic        fetch_err_q;
   logic        waiting;

   // A request is outstanding and IMEM has not answered this cycle.
   assign waiting = ((state_q == StReq) || (state_q == StKill)) && !imem_ack;

   // Next state and all handshake/pipeline controls, decoded from state and live inputs.
   always_comb begin
      state_d     = state_q;
      imem_req    = 1'b0;
      PCEnF       = 1'b0;
      PCNextF     = PCPlus4F;
      InstrF      = imem_rdata;
      InstrValidF = 1'b0;
      StallD      = 1'b0;
      FlushD      = 1'b0;
      FlushE      = 1'b0;
      unique case (state_q)
         StIdle: begin
            FlushD  = 1'b1;
            state_d = StReq;
            if (PCSrcE) begin
               PCEnF   = 1'b1;
               PCNextF = PCTargetE;
            end
         end
         StReq: begin
            imem_req = 1'b1;
            if (PCSrcE) begin
               if (imem_ack) begin
                  PCEnF   = 1'b1;
                  PCNextF = PCTargetE;
               end else begin
                  state_d = StKill;
               end
            end else if (!imem_ack) begin
               if (StallReqD) StallD = 1'b1;
               else           FlushD = 1'b1;
            end else if (!StallReqD) begin
               InstrValidF = 1'b1;
               PCEnF       = 1'b1;
            end else begin
               PCEnF   = 1'b1;
               StallD  = 1'b1;
               state_d = StHold;
            end
         end
         StHold: begin
            InstrF = buf_q;
            if (PCSrcE) begin
               PCEnF   = 1'b1;
               PCNextF = PCTargetE;
               state_d = StReq;
            end else if (StallReqD) begin
               StallD = 1'b1;
            end else begin
               InstrValidF = buf_valid_q;
               state_d     = StReq;
            end
         end
         StKill: begin
            imem_req = 1'b1;
            FlushD   = 1'b1;
            // The killed fetch's data is dropped; a same-cycle redirect beats the parked one.
            if (imem_ack) begin
               PCEnF   = 1'b1;
               PCNextF = PCSrcE ? PCTargetE : redir_q;
               state_d = StReq;
            end
         end
         default: state_d = StIdle;
      endcase
      // Redirect overrides everything below reset.
      if (PCSrcE) begin
         FlushD      = 1'b1;
         FlushE      = 1'b1;
         StallD      = 1'b0;
         InstrValidF = 1'b0;
      end
   end

   // State, skid buffer, parked redirect target, ack timer and sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         buf_q       <= '0;
         buf_valid_q <= 1'b0;
         redir_q     <= '0;
         timer_q     <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StReq && imem_ack && StallReqD && !PCSrcE) begin
            buf_q       <= imem_rdata;
            buf_valid_q <= 1'b1;
         end else if (state_d != StHold) begin
            buf_valid_q <= 1'b0;
         end
         if (PCSrcE && waiting) redir_q <= PCTargetE;
         if (waiting) begin
            if (timer_q < TimeoutVal) timer_q <= timer_q + 16'd1;
            if (timer_q + 16'd1 >= TimeoutVal) fetch_err_q <= 1'b1;
         end else begin
            timer_q <= '0;
         end
      end
   end

   assign fetch_err = fetch_err_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_wait_q;
   logic [31:0] perf_redir_q;

   // Free-running wrap-around performance counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_wait_q  <= '0;
         perf_redir_q <= '0;
      end else begin
         if (waiting) perf_wait_q  <= perf_wait_q + 32'd1;
         if (PCSrcE)  perf_redir_q <= perf_redir_q + 32'd1;
      end
   end

   assign perf_wait  = perf_wait_q;
   assign perf_redir = perf_redir_q;
`else
   assign perf_wait  = '0;
   assign perf_redir = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the fetch pipeline kept in this file.
module tb_fetch_sequencer;

   localparam int unsigned TO = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        PCSrcE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic [31:0] PCPlus4F = '0;
   logic        StallReqD = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req, PCEnF, InstrValidF, StallD, FlushD, FlushE, fetch_err;
   logic [31:0] PCNextF, InstrF, perf_wait, perf_redir;

   int checks = 0;
   int errors = 0;

   // Model: first cycle after reset, words parked for a stalled decode, redirect waiting
   // behind a doomed fetch, run of unanswered request cycles, and counters.
   bit          m_fresh;
   logic [31:0] m_held[$];
   bit          m_killing;
   logic [31:0] m_pending;
   int unsigned m_wait_run;
   bit          m_err;
   logic [31:0] m_perf_wait, m_perf_redir;

   fetch_sequencer #(.ACK_TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .PCPlus4F   (PCPlus4F),
      .StallReqD  (StallReqD),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .imem_req   (imem_req),
      .PCEnF      (PCEnF),
      .PCNextF    (PCNextF),
      .InstrF     (InstrF),
      .InstrValidF(InstrValidF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .FlushE     (FlushE),
      .fetch_err  (fetch_err),
      .perf_wait  (perf_wait),
      .perf_redir (perf_redir)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs();
      logic [31:0] ew, er;
`ifdef FETCH_PERF_CNT_EN
      ew = m_perf_wait;
      er = m_perf_redir;
`else
      ew = '0;
      er = '0;
`endif
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
      chk("perf_wait", perf_wait, ew);
      chk("perf_redir", perf_redir, er);
   endtask

   // Called at posedge+1; asserts reset mid-cycle and releases it a cycle later.
   task automatic do_reset();
      PCSrcE = 1'b0; StallReqD = 1'b0; imem_ack = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
      chk("rst_flushd", {31'b0, FlushD}, 32'd1);
      m_fresh = 1'b1; m_held.delete(); m_killing = 1'b0; m_pending = '0;
      m_wait_run = 0; m_err = 1'b0; m_perf_wait = '0; m_perf_redir = '0;
      chk_regs();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
   task automatic step(input logic src, input logic [31:0] tgt, input logic stl,
                       input logic ack, input logic [31:0] rd);
      logic        e_req, e_pcen, e_valid, e_stall, e_fd, e_fe, waiting;
      logic [31:0] e_next, e_instr;
      PCSrcE = src; PCTargetE = tgt; StallReqD = stl; imem_ack = ack; imem_rdata = rd;
      PCPlus4F = $urandom;
      @(negedge clk);
      chk_regs();
      e_req = 0; e_pcen = 0; e_valid = 0; e_stall = 0; e_fd = src; e_fe = src;
      e_next = '0; e_instr = '0; waiting = 0;
      if (m_fresh) begin
         e_fd = 1;
         if (src) begin e_pcen = 1; e_next = tgt; end
         m_fresh = 0;
      end else if (m_held.size() != 0) begin
         if (src) begin
            e_pcen = 1; e_next = tgt; m_held.delete();
         end else if (stl) e_stall = 1;
         else begin
            e_valid = 1; e_instr = m_held.pop_front();
         end
      end else if (m_killing) begin
         e_req = 1; e_fd = 1; waiting = !ack;
         if (ack) begin
            e_pcen = 1; e_next = src ? tgt : m_pending; m_killing = 0;
         end else if (src) m_pending = tgt;
      end else begin
         e_req = 1; waiting = !ack;
         if (src) begin
            if (ack) begin e_pcen = 1; e_next = tgt; end
            else begin m_pending = tgt; m_killing = 1; end
         end else if (!ack) begin
            if (stl) e_stall = 1; else e_fd = 1;
         end else begin
            e_pcen = 1; e_next = PCPlus4F;
            if (stl) begin e_stall = 1; m_held.push_back(rd); end
            else begin e_valid = 1; e_instr = rd; end
         end
      end
      chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      chk("pcen", {31'b0, PCEnF}, {31'b0, e_pcen});
      if (e_pcen) chk("pcnext", PCNextF, e_next);
      chk("valid", {31'b0, InstrValidF}, {31'b0, e_valid});
      if (e_valid) chk("instr", InstrF, e_instr);
      chk("stalld", {31'b0, StallD}, {31'b0, e_stall});
      chk("flushd", {31'b0, FlushD}, {31'b0, e_fd});
      chk("flushe", {31'b0, FlushE}, {31'b0, e_fe});
      if (waiting) begin
         m_wait_run++;
         m_perf_wait++;
         if (m_wait_run >= TO) m_err = 1'b1;
      end else begin
         m_wait_run = 0;
      end
      if (src) m_perf_redir++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // Zero-wait IMEM, no stalls.
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1, $urandom);
      // Ack delayed three cycles.
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, $urandom);
      step(1'b0, 32'h0, 1'b0, 1'b1, $urandom);
      // Decode stall for four cycles with the ack on the first, then release.
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h00500093);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, $urandom);
      step(1'b0, 32'h0, 1'b0, 1'b0, $urandom);
      // Redirect while a fetch is outstanding; ack arrives two cycles later.
      step(1'b1, 32'h40, 1'b0, 1'b0, $urandom);
      step(1'b0, 32'h0, 1'b0, 1'b0, $urandom);
      step(1'b0, 32'h0, 1'b0, 1'b1, $urandom);
      step(1'b0, 32'h0, 1'b0, 1'b1, $urandom);

      // Random traffic.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) < 7, $urandom);

      // Ack never returns: timeout flag sets and sticks.
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b0, $urandom);
      // Enter KILL, linger, then reset mid-cycle.
      step(1'b1, 32'h80, 1'b0, 1'b0, $urandom);
      step(1'b0, 32'h0, 1'b0, 1'b0, $urandom);
      do_reset();
      for (int i = 0; i < 20; i++)
         step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) < 7, $urandom);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
